// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly datapath: mode encoding,
// default modulus and the Barrett constant helper.
package ntt_pkg;

    typedef enum logic {
        MODE_CT = 1'b0,   // Cooley-Tukey (forward NTT)
        MODE_GS = 1'b1    // Gentleman-Sande (inverse NTT)
    } bfly_mode_e;

    // 2^32 - 2^20 + 1
    localparam longint unsigned Q_DEFAULT = 64'd4293918721;

    // Barrett constant floor(2^(2*dw) / q); elaboration-time only
    function automatic logic [127:0] calc_mu(input logic [63:0] q, input int unsigned dw);
        logic [127:0] num;
        num = 128'd1 << (2 * dw);
        return num / {64'd0, q};
    endfunction

endpackage

// File: rtl/mod_mul_barrett.sv
// Three-stage modular multiplier p = (a * b) mod Q using Barrett reduction.
// Stage A forms the full product, stage B the quotient estimate, stage C
// subtracts q*Q and applies up to two corrections (estimate is short by <= 2).
module mod_mul_barrett
    import ntt_pkg::*;
#(
    parameter int unsigned   DW = 32,
    parameter logic [DW-1:0] Q  = DW'(Q_DEFAULT),
    parameter logic [DW:0]   MU = (DW+1)'(calc_mu(64'(Q), DW))
) (
    input  logic          clk,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] p
);

    logic [2*DW-1:0] prod_s1;
    logic [DW:0]     q_s2;
    logic [DW+1:0]   plo_s2;

    logic [2*DW+1:0] qmul;
    logic [DW:0]     q_est;
    logic [DW+1:0]   qq;
    logic [DW+1:0]   r0;
    logic [DW+1:0]   r1;
    logic [DW+1:0]   r2;

    // Quotient estimate and remainder correction
    always_comb begin
        qmul  = (2*DW+2)'(prod_s1[2*DW-1:DW-1]) * (2*DW+2)'(MU);
        q_est = (DW+1)'(qmul >> (DW + 1));
        // remainder is < 3Q, so only the low DW+2 bits of q*Q matter
        qq    = (DW+2)'(q_s2) * (DW+2)'(Q);
        r0    = plo_s2 - qq;
        r1    = (r0 >= (DW+2)'(Q)) ? r0 - (DW+2)'(Q) : r0;
        r2    = (r1 >= (DW+2)'(Q)) ? r1 - (DW+2)'(Q) : r1;
    end

    // Pipeline registers, held when the enclosing pipeline stalls
    always_ff @(posedge clk) begin
        if (en) begin
            prod_s1 <= (2*DW)'(a) * (2*DW)'(b);
            q_s2    <= q_est;
            plo_s2  <= prod_s1[DW+1:0];
            p       <= r2[DW-1:0];
        end
    end

endmodule

// File: rtl/ntt_bfly_pipe.sv
// Five-stage pipelined NTT/INTT butterfly with valid/ready handshake.
// Stage 1 prepares operands (and the GS difference), stages 2-4 are the
// Barrett multiplier with a delay-matched side path, stage 5 combines.
module ntt_bfly_pipe
    import ntt_pkg::*;
#(
    parameter int unsigned   DW = 32,
    parameter logic [DW-1:0] Q  = DW'(Q_DEFAULT),
    parameter logic [DW:0]   MU = (DW+1)'(calc_mu(64'(Q), DW)),
    parameter int unsigned   TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_mode,
    input  logic [DW-1:0] in_x,
    input  logic [DW-1:0] in_y,
    input  logic [DW-1:0] in_w,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_x,
    output logic [DW-1:0] out_y,
    output logic [TW-1:0] out_tag,
    output logic          out_err
);

    logic adv;
    logic [4:1] v;

    bfly_mode_e    mode_d [1:4];
    logic          err_d  [1:4];
    logic [TW-1:0] tag_d  [1:4];
    logic [DW-1:0] pass_d [1:4];
    logic [DW-1:0] ma_s1;
    logic [DW-1:0] mb_s1;
    logic [DW-1:0] prod;

    logic [DW:0]   sum_w;
    logic [DW:0]   dif_w;
    logic [DW-1:0] sum_r;
    logic [DW-1:0] dif_r;
    logic          err_in;

    logic [DW:0]   ex_w;
    logic [DW:0]   ey_w;
    logic [DW-1:0] ex_r;
    logic [DW-1:0] ey_r;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // Stage-1 add/sub with a single conditional correction and range check
    always_comb begin
        sum_w  = {1'b0, in_x} + {1'b0, in_y};
        dif_w  = {1'b0, in_x} - {1'b0, in_y};
        sum_r  = DW'((sum_w >= {1'b0, Q}) ? sum_w - {1'b0, Q} : sum_w);
        dif_r  = DW'(dif_w[DW] ? dif_w + {1'b0, Q} : dif_w);
        err_in = (in_x >= Q) | (in_y >= Q) | (in_w >= Q);
    end

    // Stage-5 combine of the delayed side path with the product
    always_comb begin
        ex_w = {1'b0, pass_d[4]} + {1'b0, prod};
        ey_w = {1'b0, pass_d[4]} - {1'b0, prod};
        ex_r = DW'((ex_w >= {1'b0, Q}) ? ex_w - {1'b0, Q} : ex_w);
        ey_r = DW'(ey_w[DW] ? ey_w + {1'b0, Q} : ey_w);
    end

    mod_mul_barrett #(
        .DW (DW),
        .Q  (Q),
        .MU (MU)
    ) u_mul (
        .clk (clk),
        .en  (adv),
        .a   (ma_s1),
        .b   (mb_s1),
        .p   (prod)
    );

    // Stage valid bits: the only control state
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else if (adv) begin
            v <= {v[3:1], in_valid};
        end
    end

    // Unreset datapath: operand select at stage 1, side path delayed to match the multiplier
    always_ff @(posedge clk) begin
        if (adv) begin
            mode_d[1] <= bfly_mode_e'(in_mode);
            err_d[1]  <= err_in;
            tag_d[1]  <= in_tag;
            mb_s1     <= in_w;
            if (bfly_mode_e'(in_mode) == MODE_GS) begin
                pass_d[1] <= sum_r;
                ma_s1     <= dif_r;
            end else begin
                pass_d[1] <= in_x;
                ma_s1     <= in_y;
            end
            for (int unsigned i = 2; i <= 4; i++) begin
                mode_d[i] <= mode_d[i-1];
                err_d[i]  <= err_d[i-1];
                tag_d[i]  <= tag_d[i-1];
                pass_d[i] <= pass_d[i-1];
            end
        end
    end

    // Output register stage, reset to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else if (adv) begin
            out_valid <= v[4];
            if (v[4]) begin
                out_tag <= tag_d[4];
                out_err <= err_d[4];
                if (mode_d[4] == MODE_GS) begin
                    out_x <= pass_d[4];
                    out_y <= prod;
                end else begin
                    out_x <= ex_r;
                    out_y <= ey_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_ntt_bfly_pipe.sv
// Self-checking bench for ntt_bfly_pipe (DW=12, Q=3329): directed table,
// random mixed-mode stream under back-pressure, latency and reset flush.
module tb_ntt_bfly_pipe;

    localparam int unsigned QV = 3329;

    typedef struct packed {
        logic        m;
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] w;
        logic [11:0] ex;
        logic [11:0] ey;
        logic        ee;
    } vec_t;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [7:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [11:0] in_x;
    logic [11:0] in_y;
    logic [11:0] in_w;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_x;
    logic [11:0] out_y;
    logic [7:0]  out_tag;
    logic        out_err;

    int   checks = 0;
    int   errors = 0;
    int   waits  = 0;
    logic rnd_ready = 1'b0;
    exp_t sb_q[$];

    ntt_bfly_pipe #(
        .DW (12),
        .Q  (12'd3329),
        .MU (13'd5039),
        .TW (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_w      (in_w),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t golden(input logic m, input int unsigned x, input int unsigned y,
                                    input int unsigned w, input logic [7:0] tag);
        exp_t e;
        int unsigned p;
        int unsigned d;
        if (m == 1'b0) begin
            p   = (w * y) % QV;
            e.x = 12'((x + p) % QV);
            e.y = 12'((x + QV - p) % QV);
        end else begin
            d   = (x + QV - y) % QV;
            e.x = 12'((x + y) % QV);
            e.y = 12'((d * w) % QV);
        end
        e.tag = tag;
        e.err = (x >= QV) || (y >= QV) || (w >= QV);
        return e;
    endfunction

    // Present one sample starting just after a rising edge; returns just after its acceptance edge
    task automatic drive(input logic m, input logic [11:0] x, input logic [11:0] y,
                         input logic [11:0] w, input logic [7:0] tag, input exp_t e);
        in_valid = 1'b1;
        in_mode  = m;
        in_x     = x;
        in_y     = y;
        in_w     = w;
        in_tag   = tag;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            waits++;
            @(posedge clk);
            #1;
        end
        errors++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    // Accept, then count cycles until out_valid (out_ready held high)
    task automatic latency(input string name, input logic m, input logic [11:0] x,
                           input logic [11:0] y, input logic [11:0] w, input logic [7:0] tag);
        int n;
        drive(m, x, y, w, tag, golden(m, x, y, w, tag));
        n = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n = k;
            if (out_valid) break;
        end
        check(name, 32'(n), 32'd5);
    endtask

    // Back-pressure generator
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard monitor: compare every output transfer against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got tag %0d expected no output", out_tag);
                end else begin
                    e = sb_q.pop_front();
                    check("out_x", 32'(out_x), 32'(e.x));
                    check("out_y", 32'(out_y), 32'(e.y));
                    check("out_tag", 32'(out_tag), 32'(e.tag));
                    check("out_err", 32'(out_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        exp_t e;
        int   w0;

        tbl[0] = '{1'b0, 12'd5,    12'd7,    12'd3,    12'd26, 12'd3313, 1'b0};
        tbl[1] = '{1'b1, 12'd5,    12'd7,    12'd3,    12'd12, 12'd3323, 1'b0};
        tbl[2] = '{1'b0, 12'd3328, 12'd3328, 12'd3328, 12'd0,  12'd3327, 1'b0};
        tbl[3] = '{1'b0, 12'd0,    12'd1,    12'd1,    12'd1,  12'd3328, 1'b0};
        tbl[4] = '{1'b0, 12'd3329, 12'd7,    12'd3,    12'd21, 12'd3308, 1'b1};
        tbl[5] = '{1'b1, 12'd10,   12'd4,    12'd2,    12'd14, 12'd12,   1'b0};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_mode  = 1'b0;
        in_x     = '0;
        in_y     = '0;
        in_w     = '0;
        in_tag   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_x", 32'(out_x), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed table, back-to-back with out_ready high
        waits = 0;
        for (int i = 0; i < 6; i++) begin
            e.x   = tbl[i].ex;
            e.y   = tbl[i].ey;
            e.tag = 8'(8'h10 + i);
            e.err = tbl[i].ee;
            drive(tbl[i].m, tbl[i].x, tbl[i].y, tbl[i].w, 8'(8'h10 + i), e);
        end
        check("burst_no_stall", 32'(waits), 32'd0);
        drain("table_drain");
        @(posedge clk);
        #1;

        latency("latency_ct", 1'b0, 12'd5, 12'd7, 12'd3, 8'hA0);
        drain("lat_ct_drain");
        @(posedge clk);
        #1;
        latency("latency_gs", 1'b1, 12'd5, 12'd7, 12'd3, 8'hA1);
        drain("lat_gs_drain");
        @(posedge clk);
        #1;

        // Random alternating-mode stream under pseudo-random back-pressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [11:0] rx;
            logic [11:0] ry;
            logic [11:0] rw;
            logic        m;
            rx = 12'($urandom_range(0, QV - 1));
            ry = 12'($urandom_range(0, QV - 1));
            rw = 12'($urandom_range(0, QV - 1));
            m  = 1'(i % 2);
            drive(m, rx, ry, rw, 8'(8'h40 + i), golden(m, rx, ry, rw, 8'(8'h40 + i)));
        end
        drain("random_drain");
        rnd_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset with three samples in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 12'(100 + i), 12'd2, 12'd3, 8'(8'hE0 + i), golden(1'b0, 100 + i, 2, 3, 8'(8'hE0 + i)));
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        latency("latency_post_rst", 1'b1, 12'd9, 12'd3, 12'd2, 8'hF0);
        drain("final_drain");

        w0 = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) w0++;
        end
        check("idle_no_output", 32'(w0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
